// File: rtl/stage2_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stage2_decode : decode stage, PC tracking, branch kill, load-use stall
// Revision 1.0
// ---------------------------------------------------------------------------
module stage2_decode #(
  parameter int PCW      = 30,
  parameter int NREGBITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                stall_i,
  input  logic                take_branch_i,
  input  logic [31:0]         ir_i,
  input  logic [PCW-1:0]      nextpc_i,
  output logic                stall_o,
  output logic [NREGBITS-1:0] ra_addr_o,
  output logic [NREGBITS-1:0] rb_addr_o,
  output logic                valid_o,
  output logic [PCW-1:0]      pc_o,
  output logic [3:0]          op_o,
  output logic [NREGBITS-1:0] rd_o,
  output logic [NREGBITS-1:0] ra_o,
  output logic [NREGBITS-1:0] rb_o,
  output logic [31:0]         imm_o,
  output logic                is_load_o,
  output logic                is_store_o,
  output logic                is_branch_o,
  output logic                wb_en_o,
  output logic                illegal_o
);

  localparam logic [3:0] c_OP_ALU = 4'd0;
  localparam logic [3:0] c_OP_ALI = 4'd1;
  localparam logic [3:0] c_OP_LD  = 4'd2;
  localparam logic [3:0] c_OP_ST  = 4'd3;
  localparam logic [3:0] c_OP_BR  = 4'd4;
  localparam logic [3:0] c_OP_JAL = 4'd5;

  typedef struct packed {
    logic [3:0]          op;
    logic [NREGBITS-1:0] rd;
    logic [NREGBITS-1:0] ra;
    logic [NREGBITS-1:0] rb;
    logic [31:0]         imm;
    logic                ld;
    logic                st;
    logic                br;
    logic                wb;
    logic                ill;
  } dec_t;

  dec_t           dec;
  dec_t           bndl_d, bndl_q;
  logic           valid_d, valid_q;
  logic [PCW-1:0] pc_d, pc_q;
  logic [PCW-1:0] ir_pc_d, ir_pc_q;
  logic           slot_v_d, slot_v_q;
  logic           hazard;
  logic           rb_used;

  always_comb begin
    dec     = '0;
    dec.op  = ir_i[31:28];
    dec.rd  = NREGBITS'(ir_i[27:24]);
    dec.ra  = NREGBITS'(ir_i[23:20]);
    dec.rb  = NREGBITS'(ir_i[19:16]);
    dec.imm = {{16{ir_i[15]}}, ir_i[15:0]};
    dec.ld  = (dec.op == c_OP_LD);
    dec.st  = (dec.op == c_OP_ST);
    dec.br  = (dec.op == c_OP_BR);
    dec.ill = (dec.op > c_OP_JAL);
    dec.wb  = ((dec.op == c_OP_ALU) || (dec.op == c_OP_ALI) ||
               (dec.op == c_OP_LD)  || (dec.op == c_OP_JAL)) && (dec.rd != '0);
  end

  // Only reg-reg ALU, store and branch actually read port B.
  assign rb_used = (dec.op == c_OP_ALU) || (dec.op == c_OP_ST) || (dec.op == c_OP_BR);

  assign hazard  = valid_q && bndl_q.ld && (bndl_q.rd != '0) && slot_v_q && !take_branch_i &&
                   ((bndl_q.rd == dec.ra) || (rb_used && (bndl_q.rd == dec.rb)));

  assign stall_o   = stall_i | hazard;
  assign ra_addr_o = dec.ra;
  assign rb_addr_o = dec.rb;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    bndl_d   = bndl_q;
    ir_pc_d  = stall_o ? ir_pc_q : nextpc_i;
    slot_v_d = slot_v_q | ~stall_o;
    if (take_branch_i) begin
      valid_d = 1'b0;
      pc_d    = '0;
      bndl_d  = '0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
      pc_d    = '0;
      bndl_d  = '0;
    end else begin
      valid_d = slot_v_q;
      pc_d    = ir_pc_q;
      bndl_d  = dec;
      if (!slot_v_q) begin
        bndl_d.ld  = 1'b0;
        bndl_d.st  = 1'b0;
        bndl_d.br  = 1'b0;
        bndl_d.wb  = 1'b0;
        bndl_d.ill = 1'b0;
      end
    end
  end

  // All-ones PC reset makes the first fetched word pair with PC 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      bndl_q   <= '0;
      ir_pc_q  <= '1;
      slot_v_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      bndl_q   <= bndl_d;
      ir_pc_q  <= ir_pc_d;
      slot_v_q <= slot_v_d;
    end
  end

  assign valid_o     = valid_q;
  assign pc_o        = pc_q;
  assign op_o        = bndl_q.op;
  assign rd_o        = bndl_q.rd;
  assign ra_o        = bndl_q.ra;
  assign rb_o        = bndl_q.rb;
  assign imm_o       = bndl_q.imm;
  assign is_load_o   = bndl_q.ld;
  assign is_store_o  = bndl_q.st;
  assign is_branch_o = bndl_q.br;
  assign wb_en_o     = bndl_q.wb;
  assign illegal_o   = bndl_q.ill;

endmodule
`default_nettype wire

// File: tb/tb_stage2_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stage2_decode : directed scoreboard bench for stage2_decode
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_stage2_decode;

  localparam int PCW = 30;
  localparam int NRB = 4;

  typedef struct packed {
    logic           valid;
    logic [PCW-1:0] pc;
    logic [3:0]     op;
    logic [NRB-1:0] rd;
    logic [NRB-1:0] ra;
    logic [NRB-1:0] rb;
    logic [31:0]    imm;
    logic           ld;
    logic           st;
    logic           br;
    logic           wb;
    logic           ill;
  } bndl_t;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           stall_i;
  logic           take_branch_i;
  logic [31:0]    ir_i;
  logic [PCW-1:0] nextpc_i;
  logic           stall_o;
  logic [NRB-1:0] ra_addr_o, rb_addr_o;
  logic           valid_o;
  logic [PCW-1:0] pc_o;
  logic [3:0]     op_o;
  logic [NRB-1:0] rd_o, ra_o, rb_o;
  logic [31:0]    imm_o;
  logic           is_load_o, is_store_o, is_branch_o, wb_en_o, illegal_o;

  int    checks   = 0;
  int    failures = 0;
  bndl_t sb[$];
  bndl_t last_exp;

  stage2_decode #(.PCW(PCW), .NREGBITS(NRB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .take_branch_i(take_branch_i),
    .ir_i(ir_i), .nextpc_i(nextpc_i), .stall_o(stall_o),
    .ra_addr_o(ra_addr_o), .rb_addr_o(rb_addr_o), .valid_o(valid_o), .pc_o(pc_o),
    .op_o(op_o), .rd_o(rd_o), .ra_o(ra_o), .rb_o(rb_o), .imm_o(imm_o),
    .is_load_o(is_load_o), .is_store_o(is_store_o), .is_branch_o(is_branch_o),
    .wb_en_o(wb_en_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bndl_t model(input logic [31:0] ir, input logic [PCW-1:0] pc);
    bndl_t b;
    b.valid = 1'b1;
    b.pc    = pc;
    b.op    = ir[31:28];
    b.rd    = ir[27:24];
    b.ra    = ir[23:20];
    b.rb    = ir[19:16];
    b.imm   = {{16{ir[15]}}, ir[15:0]};
    b.ld    = (b.op == 4'd2);
    b.st    = (b.op == 4'd3);
    b.br    = (b.op == 4'd4);
    b.ill   = (b.op >= 4'd6);
    b.wb    = (b.op inside {4'd0, 4'd1, 4'd2, 4'd5}) && (b.rd != 4'd0);
    return b;
  endfunction

  function automatic bndl_t observe();
    return {valid_o, pc_o, op_o, rd_o, ra_o, rb_o, imm_o,
            is_load_o, is_store_o, is_branch_o, wb_en_o, illegal_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input bndl_t obs, input bndl_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check stall_o, clock, then check the bundle.
  task automatic cyc(input logic [31:0] ir, input logic [PCW-1:0] pc, input logic [PCW-1:0] npc,
                     input logic br, input logic st, input logic dec, input logic exp_stall);
    bndl_t e;
    ir_i = ir; nextpc_i = npc; take_branch_i = br; stall_i = st;
    if (dec) sb.push_back(model(ir, pc));
    #1;
    chk("stall_o", {31'd0, stall_o}, {31'd0, exp_stall});
    @(posedge clk_i); #1;
    if (st) begin
      chk_b("hold", observe(), last_exp);
    end else if (dec) begin
      e = sb.pop_front();
      last_exp = e;
      chk_b("bundle", observe(), e);
    end else begin
      chk("bubble", {26'd0, valid_o, is_load_o, is_store_o, is_branch_o, wb_en_o, illegal_o}, 32'd0);
    end
  endtask

  initial begin
    rst_ni = 1'b0; stall_i = 1'b0; take_branch_i = 1'b0; ir_i = '0; nextpc_i = '0;
    last_exp = '0;
    #12;
    chk_b("reset_bundle", observe(), '0);
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    rst_ni = 1'b1;

    cyc(32'h0000_0000, '0,  30'd0,  0, 0, 0, 0);
    cyc(32'h1321_0005, 30'd0, 30'd1, 0, 0, 1, 0);
    chk("first_op", {28'd0, op_o}, 32'd1);
    chk("first_imm", imm_o, 32'd5);
    chk("first_wb", {31'd0, wb_en_o}, 32'd1);
    cyc(32'h1100_FFF0, 30'd1, 30'd2, 0, 0, 1, 0);
    chk("neg_imm", imm_o, 32'hFFFF_FFF0);
    cyc(32'h1021_0007, 30'd2, 30'd3, 0, 0, 1, 0);
    chk("rd0_wb", {31'd0, wb_en_o}, 32'd0);

    // LOAD r5 then ALU r6=r5+r1: one bubble, then re-decode at the same PC
    cyc(32'h2540_0010, 30'd3, 30'd4, 0, 0, 1, 0);
    cyc(32'h0651_0000, 30'd4, 30'd5, 0, 0, 0, 1);
    cyc(32'h0651_0000, 30'd4, 30'd5, 0, 0, 1, 0);
    chk("hazard_pc", {2'd0, pc_o}, 32'd4);

    // LOAD r5 then LOAD r7 from r4: back-to-back
    cyc(32'h2540_0010, 30'd5, 30'd6, 0, 0, 1, 0);
    cyc(32'h2740_0000, 30'd6, 30'd7, 0, 0, 1, 0);

    // taken branch to 0x40 kills the slot
    cyc(32'h1000_0000, 30'd7, 30'h40, 1, 0, 0, 0);
    cyc(32'h1880_0001, 30'h40, 30'h41, 0, 0, 1, 0);
    chk("branch_pc", {2'd0, pc_o}, 32'h40);
    cyc(32'h3120_0004, 30'h41, 30'h42, 0, 0, 1, 0);

    // downstream stall for three cycles freezes the bundle
    cyc(32'h0123_0000, 30'h42, 30'h43, 0, 1, 0, 1);
    cyc(32'h0123_0000, 30'h42, 30'h43, 0, 1, 0, 1);
    cyc(32'h0123_0000, 30'h42, 30'h43, 0, 1, 0, 1);
    cyc(32'h0123_0000, 30'h42, 30'h43, 0, 0, 1, 0);

    cyc(32'hF300_0000, 30'h43, 30'h44, 0, 0, 1, 0);
    chk("illegal", {30'd0, illegal_o, wb_en_o}, 32'd2);
    cyc(32'h2230_0000, 30'h44, 30'h45, 0, 0, 1, 0);

    // asynchronous reset mid-cycle
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_valid", {31'd0, valid_o}, 32'd0);
    chk_b("async_bundle", observe(), '0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
